// File: rtl/tensor_issue_sched.sv
// Per-warp issue scheduler for the tensor core.
//
// Each warp holds at most one tensor op, tracked by a small IDLE/PEND/BUSY FSM. Warps with
// pending work are arbitrated round-robin and emit fire steps (warp, B column, accumulate
// source) to the thread-group datapath. Every accepted fire pushes writeback metadata into a
// FIFO that the datapath retire stage pops.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   in_valid_i / in_ready_o   op offer; ready when the addressed warp is idle
//   in_wid_i, in_op_i, in_rd_i  issuing warp, op code, destination register / tile base
//   fire_valid_o / fire_ready_i  fire step handshake
//   fire_wid_o, fire_col_o, fire_acc_buf_o, fire_last_o  fire step fields
//   wb_valid_o / wb_ready_i   writeback metadata FIFO head / pop
//   wb_wid_o, wb_reg_o, wb_to_reg_o  head entry fields
//   warp_busy_o               per-warp non-idle flags
module tensor_issue_sched #(
  parameter int unsigned NUM_WARPS     = 8,
  parameter int unsigned THREAD_N      = 4,
  parameter int unsigned NUM_TILE_BUFS = 2,
  parameter int unsigned REG_W         = 5,
  parameter int unsigned WB_FIFO_DEPTH = 4,
  localparam int unsigned WidW         = $clog2(NUM_WARPS),
  localparam int unsigned ColW         = $clog2(THREAD_N)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WidW-1:0]      in_wid_i,
  input  logic [1:0]           in_op_i,
  input  logic [REG_W-1:0]     in_rd_i,
  output logic                 fire_valid_o,
  input  logic                 fire_ready_i,
  output logic [WidW-1:0]      fire_wid_o,
  output logic [ColW-1:0]      fire_col_o,
  output logic                 fire_acc_buf_o,
  output logic                 fire_last_o,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [WidW-1:0]      wb_wid_o,
  output logic [REG_W-1:0]     wb_reg_o,
  output logic                 wb_to_reg_o,
  output logic [NUM_WARPS-1:0] warp_busy_o
);

  localparam int unsigned PtrW         = $clog2(WB_FIFO_DEPTH);
  localparam int unsigned CntW         = $clog2(WB_FIFO_DEPTH + 1);
  localparam int unsigned WarpsPerBufW = $clog2(NUM_WARPS / NUM_TILE_BUFS);

  localparam logic [1:0] OpAccBufWbBuf = 2'd1;

  typedef enum logic [1:0] {StIdle, StPend, StBusy} warp_state_e;

  // Per-warp op context
  warp_state_e          state_q [NUM_WARPS];
  warp_state_e          state_d [NUM_WARPS];
  logic [1:0]           op_q    [NUM_WARPS];
  logic [1:0]           op_d    [NUM_WARPS];
  logic [REG_W-1:0]     rd_q    [NUM_WARPS];
  logic [REG_W-1:0]     rd_d    [NUM_WARPS];
  logic [ColW-1:0]      col_q   [NUM_WARPS];
  logic [ColW-1:0]      col_d   [NUM_WARPS];

  // Arbitration state
  logic                 lock_q, lock_d;
  logic [WidW-1:0]      lock_wid_q, lock_wid_d;
  logic [WidW-1:0]      rr_q, rr_d;

  // Writeback FIFO
  logic [WidW-1:0]      mem_wid    [WB_FIFO_DEPTH];
  logic [REG_W-1:0]     mem_reg    [WB_FIFO_DEPTH];
  logic                 mem_to_reg [WB_FIFO_DEPTH];
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CntW-1:0]      count_q;

  logic [NUM_WARPS-1:0] eligible;
  logic                 arb_found;
  logic [WidW-1:0]      arb_wid;
  logic [WidW-1:0]      grant_wid;
  logic [1:0]           grant_op;
  logic [REG_W-1:0]     grant_rd;
  logic [ColW-1:0]      grant_col;
  logic                 grant_last;
  logic                 fifo_full;
  logic                 fire_valid;
  logic                 fire_hs;
  logic                 wb_pop;
  logic [ColW-1:0]      col_sum;
  logic [WidW-1:0]      tile_buf;
  logic [REG_W-1:0]     push_reg;
  logic                 push_to_reg;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(WB_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      eligible[i] = (state_q[i] != StIdle);
    end
  end

  always_comb begin : rr_search
    logic [WidW-1:0] idx;
    arb_found = 1'b0;
    arb_wid   = '0;
    idx       = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = rr_q + WidW'(i);
      if (!arb_found && eligible[idx]) begin
        arb_found = 1'b1;
        arb_wid   = idx;
      end
    end
  end

  // A locked grant holds until handshake; the FIFO cannot fill meanwhile since only a fire pushes.
  assign grant_wid  = lock_q ? lock_wid_q : arb_wid;
  assign grant_op   = op_q[grant_wid];
  assign grant_rd   = rd_q[grant_wid];
  assign grant_col  = col_q[grant_wid];
  assign grant_last = (grant_op != OpAccBufWbBuf) || (grant_col == ColW'(THREAD_N - 1));

  // Full is judged on the registered count, so a same-cycle pop does not unblock a fire.
  assign fifo_full  = (count_q == CntW'(WB_FIFO_DEPTH));
  assign fire_valid = arb_found && !fifo_full;
  assign fire_hs    = fire_valid && fire_ready_i;
  assign wb_pop     = (count_q != '0) && wb_ready_i;

  always_comb begin
    lock_d     = lock_q;
    lock_wid_d = lock_wid_q;
    rr_d       = rr_q;
    if (fire_hs) begin
      lock_d = 1'b0;
      rr_d   = grant_wid + 1'b1;
    end else if (fire_valid) begin
      lock_d     = 1'b1;
      lock_wid_d = grant_wid;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Per-warp FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        state_q[i] <= StIdle;
        op_q[i]    <= '0;
        rd_q[i]    <= '0;
        col_q[i]   <= '0;
      end
      lock_q     <= 1'b0;
      lock_wid_q <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      col_q      <= col_d;
      lock_q     <= lock_d;
      lock_wid_q <= lock_wid_d;
      rr_q       <= rr_d;
    end
  end

  // Accept and fire never target the same warp: an accepting warp is idle, a firing one is not.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    col_d   = col_q;
    if (in_valid_i && in_ready_o) begin
      state_d[in_wid_i] = StPend;
      op_d[in_wid_i]    = in_op_i;
      rd_d[in_wid_i]    = in_rd_i;
      col_d[in_wid_i]   = '0;
    end
    if (fire_hs) begin
      if (grant_last) begin
        state_d[grant_wid] = StIdle;
      end else begin
        state_d[grant_wid] = StBusy;
        col_d[grant_wid]   = grant_col + 1'b1;
      end
    end
  end

  always_comb begin
    in_ready_o     = (state_q[in_wid_i] == StIdle);
    warp_busy_o    = eligible;
    fire_valid_o   = fire_valid;
    fire_wid_o     = fire_valid ? grant_wid : '0;
    fire_col_o     = fire_valid ? grant_col : '0;
    fire_acc_buf_o = fire_valid && !grant_op[1];
    fire_last_o    = fire_valid && grant_last;
  end

  // ---------------------------------------------------------------------------------------------
  // Writeback metadata
  // ---------------------------------------------------------------------------------------------
  // Buffered writeback rotates the tile row by the column and interleaves the tile buffers.
  assign col_sum     = grant_rd[ColW-1:0] + grant_col;
  assign tile_buf    = grant_wid >> WarpsPerBufW;
  assign push_to_reg = !grant_op[0];
  assign push_reg    = (grant_op == OpAccBufWbBuf)
                       ? REG_W'(col_sum) * REG_W'(NUM_TILE_BUFS) + REG_W'(tile_buf)
                       : grant_rd;

  always_ff @(posedge clk_i) begin
    if (fire_hs) begin
      mem_wid[wptr_q]    <= grant_wid;
      mem_reg[wptr_q]    <= push_reg;
      mem_to_reg[wptr_q] <= push_to_reg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (fire_hs) wptr_q <= ptr_inc(wptr_q);
      if (wb_pop)  rptr_q <= ptr_inc(rptr_q);
      unique case ({fire_hs, wb_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    wb_valid_o  = (count_q != '0);
    wb_wid_o    = wb_valid_o ? mem_wid[rptr_q] : '0;
    wb_reg_o    = wb_valid_o ? mem_reg[rptr_q] : '0;
    wb_to_reg_o = wb_valid_o && mem_to_reg[rptr_q];
  end

endmodule

// File: tb/tb_tensor_issue_sched.sv
// Self-checking bench for tensor_issue_sched: random ops checked by a scoreboard monitor that
// predicts arbitration, fire fields and writeback metadata from per-warp op records.
module tb_tensor_issue_sched;

  localparam int NW    = 8;
  localparam int TN    = 4;
  localparam int NTB   = 2;
  localparam int RW    = 5;
  localparam int DEPTH = 4;
  localparam int WW    = $clog2(NW);
  localparam int CW    = $clog2(TN);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_wid;
  logic [1:0]    in_op;
  logic [RW-1:0] in_rd;
  logic          fire_valid;
  logic          fire_ready;
  logic [WW-1:0] fire_wid;
  logic [CW-1:0] fire_col;
  logic          fire_acc_buf;
  logic          fire_last;
  logic          wb_valid;
  logic          wb_ready;
  logic [WW-1:0] wb_wid;
  logic [RW-1:0] wb_reg;
  logic          wb_to_reg;
  logic [NW-1:0] warp_busy;

  tensor_issue_sched #(
    .NUM_WARPS    (NW),
    .THREAD_N     (TN),
    .NUM_TILE_BUFS(NTB),
    .REG_W        (RW),
    .WB_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_wid_i      (in_wid),
    .in_op_i       (in_op),
    .in_rd_i       (in_rd),
    .fire_valid_o  (fire_valid),
    .fire_ready_i  (fire_ready),
    .fire_wid_o    (fire_wid),
    .fire_col_o    (fire_col),
    .fire_acc_buf_o(fire_acc_buf),
    .fire_last_o   (fire_last),
    .wb_valid_o    (wb_valid),
    .wb_ready_i    (wb_ready),
    .wb_wid_o      (wb_wid),
    .wb_reg_o      (wb_reg),
    .wb_to_reg_o   (wb_to_reg),
    .warp_busy_o   (warp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one outstanding op per warp plus the expected writeback queue.
  typedef struct {
    int wid;
    int regv;
    int to_reg;
  } wb_t;

  bit  active [NW];
  int  m_op   [NW];
  int  m_rd   [NW];
  int  m_col  [NW];
  int  rr;
  bit  lock;
  int  lock_w;
  wb_t wbq[$];
  bit  mon_en;
  int  n_tests;
  int  n_fail;

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NW; i++) begin
      active[i] = 1'b0;
      m_op[i]   = 0;
      m_rd[i]   = 0;
      m_col[i]  = 0;
    end
    rr     = 0;
    lock   = 1'b0;
    lock_w = 0;
    wbq.delete();
  endfunction

  // Monitor: outputs and inputs are stable at the falling edge; a handshake seen here completes
  // on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin : mon_cycle
        int  exp_w;
        bit  any;
        bit  exp_fv;
        bit  exp_wv;
        bit  last;
        int  w;
        wb_t e;
        logic [NW-1:0] eb;

        for (int i = 0; i < NW; i++) eb[i] = active[i];
        check("warp_busy", int'(warp_busy), int'(eb));
        check("in_ready", int'(in_ready), int'(!active[in_wid]));

        any   = 1'b0;
        exp_w = 0;
        for (int i = 0; i < NW; i++) begin
          w = (rr + i) % NW;
          if (!any && active[w]) begin
            any   = 1'b1;
            exp_w = w;
          end
        end
        if (lock) exp_w = lock_w;
        exp_fv = any && (wbq.size() < DEPTH);
        last   = (m_op[exp_w] != 1) || (m_col[exp_w] == TN - 1);

        check("fire_valid", int'(fire_valid), int'(exp_fv));
        if (exp_fv) begin
          check("fire_wid", int'(fire_wid), exp_w);
          check("fire_col", int'(fire_col), m_col[exp_w]);
          check("fire_acc_buf", int'(fire_acc_buf), int'(m_op[exp_w] < 2));
          check("fire_last", int'(fire_last), int'(last));
        end

        exp_wv = (wbq.size() != 0);
        check("wb_valid", int'(wb_valid), int'(exp_wv));
        if (exp_wv) begin
          check("wb_wid", int'(wb_wid), wbq[0].wid);
          check("wb_reg", int'(wb_reg), wbq[0].regv);
          check("wb_to_reg", int'(wb_to_reg), wbq[0].to_reg);
          if (wb_ready) void'(wbq.pop_front());
        end

        if (exp_fv && fire_ready) begin
          e.wid = exp_w;
          case (m_op[exp_w])
            1: begin
              e.regv   = ((((m_rd[exp_w] + m_col[exp_w]) % TN) * NTB) + exp_w / (NW / NTB))
                         % (1 << RW);
              e.to_reg = 0;
            end
            3: begin
              e.regv   = m_rd[exp_w];
              e.to_reg = 0;
            end
            default: begin
              e.regv   = m_rd[exp_w];
              e.to_reg = 1;
            end
          endcase
          wbq.push_back(e);
          if (last) active[exp_w] = 1'b0;
          else m_col[exp_w] = m_col[exp_w] + 1;
          rr   = (exp_w + 1) % NW;
          lock = 1'b0;
        end else if (exp_fv) begin
          lock   = 1'b1;
          lock_w = exp_w;
        end
      end
    end
  end

  // One cycle: note whether the current offer is accepted, record it after the edge, then
  // drive the next cycle's inputs.
  task automatic step(input bit iv, input int w, input int op, input int rd,
                      input bit fr, input bit wr);
    bit acc;
    int aw, aop, ard;
    @(negedge clk);
    acc = in_valid && in_ready && rst_n;
    aw  = int'(in_wid);
    aop = int'(in_op);
    ard = int'(in_rd);
    @(posedge clk);
    if (acc) begin
      active[aw] = 1'b1;
      m_op[aw]   = aop;
      m_rd[aw]   = ard;
      m_col[aw]  = 0;
    end
    #1;
    in_valid   = iv;
    in_wid     = WW'(w);
    in_op      = 2'(op);
    in_rd      = RW'(rd);
    fire_ready = fr;
    wb_ready   = wr;
  endtask

  task automatic run_random(input int cycles, input int iv_pct, input int fr_pct,
                            input int wr_pct);
    for (int c = 0; c < cycles; c++) begin
      step($urandom_range(0, 99) < iv_pct, int'($urandom_range(0, NW - 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, (1 << RW) - 1)),
           $urandom_range(0, 99) < fr_pct, $urandom_range(0, 99) < wr_pct);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fire_valid"}, int'(fire_valid), 0);
    check({tag, "_fire_col"}, int'(fire_col), 0);
    check({tag, "_fire_acc_buf"}, int'(fire_acc_buf), 0);
    check({tag, "_fire_last"}, int'(fire_last), 0);
    check({tag, "_wb_valid"}, int'(wb_valid), 0);
    check({tag, "_wb_wid"}, int'(wb_wid), 0);
    check({tag, "_wb_reg"}, int'(wb_reg), 0);
    check({tag, "_wb_to_reg"}, int'(wb_to_reg), 0);
    check({tag, "_warp_busy"}, int'(warp_busy), 0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    mon_en     = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_wid     = '0;
    in_op      = '0;
    in_rd      = '0;
    fire_ready = 1'b0;
    wb_ready   = 1'b0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    for (int i = 0; i < NW; i++) begin
      in_wid = WW'(i);
      #0.1;
      check("reset_in_ready", int'(in_ready), 1);
    end
    in_wid = '0;

    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_random(600, 60, 70, 80);
    run_random(400, 60, 80, 20);   // FIFO mostly full: back-pressure on fire
    run_random(300, 40, 30, 90);   // long fire stalls: grant lock
    run_random(150, 0, 100, 100);  // drain

    // Reset in the middle of a buffered op with two metadata entries queued.
    step(1'b1, 0, 1, 9, 1'b1, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    #1;
    check("pre_rst_wb_valid", int'(wb_valid), 1);
    check("pre_rst_busy0", int'(warp_busy[0]), 1);
    check("pre_rst_entries", wbq.size(), 2);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_clear();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < NW; i++) begin
      in_wid = WW'(i);
      #0.5;
      check("post_rst_in_ready", int'(in_ready), 1);
    end
    check("post_rst_wb_valid", int'(wb_valid), 0);

    run_random(200, 50, 80, 60);
    run_random(100, 0, 100, 100);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
